shift_subtract_divider: RTL and testbench



---
 rtl/shift_subtract_divider_pkg.sv | 10 +
 rtl/shift_subtract_divider_step.sv | 15 +
 rtl/shift_subtract_divider.sv | 73 +++++++
 tb/tb_shift_subtract_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_subtract_divider_pkg.sv
// shift_subtract_divider_pkg: shared FSM state encoding and count sizing for the divider.
package shift_subtract_divider_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/shift_subtract_divider_step.sv
// shift_subtract_divider_step: one restoring shift-and-subtract iteration on {A,Q}.
module shift_subtract_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH:0] aq,
    input  logic [WIDTH-1:0] m,
    output logic [2*WIDTH:0] aq_next
);
    logic [WIDTH+1:0] t;

    // Keep the bit shifted out of A so the sign test never loses information.
    assign t       = aq[2*WIDTH:WIDTH-1] - {2'b00, m};
    assign aq_next = t[WIDTH+1] ? {aq[2*WIDTH-1:0], 1'b0}
                                : {t[WIDTH:0], aq[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/shift_subtract_divider.sv
// shift_subtract_divider: sequential unsigned restoring divider, one quotient bit per clock.
module shift_subtract_divider
    import shift_subtract_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = count_width(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] aq;
    logic [2*WIDTH:0] aq_next;
    logic [WIDTH-1:0] m;

    shift_subtract_step #(.WIDTH(WIDTH)) step (
        .aq     (aq),
        .m      (m),
        .aq_next(aq_next)
    );

    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            aq          <= '0;
            m           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (divisor != '0) begin
                        m     <= divisor;
                        aq    <= {{(WIDTH+1){1'b0}}, dividend};
                        count <= '0;
                        state <= RUN;
                    end else begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end
                end
                RUN: begin
                    aq    <= aq_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        quotient    <= aq_next[WIDTH-1:0];
                        remainder   <= aq_next[2*WIDTH-1:WIDTH];
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_subtract_divider.sv
// tb_shift_subtract_divider: scoreboard bench; expected results come from plain / and % arithmetic.
module tb_shift_subtract_divider;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int   checks = 0;
    int   failures = 0;
    int   dones = 0;
    int   cyc = 0;
    res_t exp_q[$];

    shift_subtract_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = W'(a / b);
            e.r = W'(a % b);
            e.z = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst_n && done) begin
            dones++;
            chk("busy_with_done", {31'd0, busy}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                e = exp_q.pop_front();
                chk("quotient", {28'd0, quotient}, {28'd0, e.q});
                chk("remainder", {28'd0, remainder}, {28'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end
    end

    // Waits for done with a bound; edges counts clocks after the accepting edge.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges = 0;
        busy_cyc = 0;
        while (!done && edges < 20) begin
            busy_cyc += int'(busy);
            @(posedge clk); #1;
            edges++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, output int edges, output int busy_cyc);
        @(posedge clk); #1;
        exp_q.push_back(model(a, b));
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        wait_done(edges, busy_cyc);
    endtask

    initial begin
        int e, bc, prev, d0;
        logic [W-1:0] a, b;
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_q", {28'd0, quotient}, 0);
        chk("rst_r", {28'd0, remainder}, 0);
        chk("rst_dz", {31'd0, div_by_zero}, 0);
        @(negedge clk) rst_n = 1'b1;

        op(4'd13, 4'd3, e, bc);
        chk("latency_13_3", e, W);
        chk("busy_cycles_13_3", bc, W);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_q", {28'd0, quotient}, 4);
        chk("hold_r", {28'd0, remainder}, 1);

        op(4'd15, 4'd1, e, bc);
        op(4'd3, 4'd7, e, bc);
        op(4'd0, 4'd5, e, bc);

        op(4'd9, 4'd0, e, bc);
        chk("dz_latency_le1", {31'd0, e <= 1}, 1);
        chk("dz_busy_never", bc, 0);
        op(4'd8, 4'd2, e, bc);

        // A held start with changing operands must not spawn a second operation.
        @(posedge clk); #1;
        d0 = dones;
        exp_q.push_back(model(4'd12, 4'd5));
        dividend = 4'd12;
        divisor = 4'd5;
        start = 1'b1;
        @(posedge clk); #1;
        dividend = 4'd1;
        divisor = 4'd1;
        wait_done(e, bc);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("single_done", dones - d0, 1);

        // Asynchronous reset in the middle of RUN.
        dividend = 4'd14;
        divisor = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_q", {28'd0, quotient}, 0);
        chk("arst_r", {28'd0, remainder}, 0);
        chk("arst_dz", {31'd0, div_by_zero}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {30'd0, busy, done}, 0);
        op(4'd7, 4'd2, e, bc);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            op(a, b, e, bc);
        end

        prev = -1;
        for (int i = 0; i < 256; i++) begin
            a = W'(i >> 4);
            b = W'(i);
            op(a, b, e, bc);
            if (b != 0 && prev >= 0) chk("done_spacing", cyc - prev, W + 2);
            prev = cyc;
        end

        @(posedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
